// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..10, one per clock, and keeps the final-round key.
// Optional macro KEY_STORE_EN adds an 11-entry round-key register file with a registered read port.
module aes_key_expand #(
    parameter int NR   = 10,
    parameter int RK_W = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            decrypt_i,
    input  logic [RK_W-1:0] key_i,
    output logic            busy_o,
    output logic            rk_valid_o,
    output logic [RK_W-1:0] round_key_o,
    output logic [3:0]      round_idx_o,
    output logic [RK_W-1:0] keylast_o,
    output logic            done_o
`ifdef KEY_STORE_EN
    ,
    input  logic [3:0]      rk_addr_i,
    output logic [RK_W-1:0] rk_data_o
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NR);
    localparam logic [3:0] PREV_IDX = 4'(NR - 1);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t          state;
    logic [7:0]      rcon;
    logic            decrypt;
    logic [RK_W-1:0] next_rk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Next round key derived from the key currently on the output
    always_comb begin
        next_rk = next_key(round_key_o, rcon);
    end

    // Expansion FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            rk_valid_o  <= 1'b0;
            done_o      <= 1'b0;
            round_key_o <= '0;
            round_idx_o <= 4'd0;
            keylast_o   <= '0;
            rcon        <= 8'h01;
            decrypt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state       <= EXPAND;
                        busy_o      <= 1'b1;
                        rk_valid_o  <= 1'b1;
                        round_key_o <= key_i;
                        round_idx_o <= 4'd0;
                        rcon        <= 8'h01;
                        decrypt     <= decrypt_i;
                        // Decryption starts from the cipher key, so it is the final-round key
                        if (decrypt_i) begin
                            keylast_o <= key_i;
                        end else begin
                            keylast_o <= keylast_o;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                EXPAND: begin
                    if (round_idx_o == LAST_IDX) begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        rk_valid_o <= 1'b0;
                        done_o     <= 1'b0;
                    end else begin
                        round_key_o <= next_rk;
                        round_idx_o <= round_idx_o + 4'd1;
                        rcon        <= xtime(rcon);
                        done_o      <= (round_idx_o == PREV_IDX);
                        if ((round_idx_o == PREV_IDX) && !decrypt) begin
                            keylast_o <= next_rk;
                        end else begin
                            keylast_o <= keylast_o;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    rk_valid_o <= 1'b0;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_STORE_EN
    logic [RK_W-1:0] rk_mem [0:10];
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic [RK_W-1:0] wr_data;

    // Each produced round key is written at the same edge it appears on the stream
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_data = '0;
        if ((state == IDLE) && start_i) begin
            wr_en   = 1'b1;
            wr_idx  = 4'd0;
            wr_data = key_i;
        end else if ((state == EXPAND) && (round_idx_o != LAST_IDX)) begin
            wr_en   = 1'b1;
            wr_idx  = round_idx_o + 4'd1;
            wr_data = next_rk;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Register file plus registered read port; a same-cycle read sees the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= 10; i++) begin
                rk_mem[i] <= '0;
            end
            rk_data_o <= '0;
        end else begin
            if (wr_en) begin
                rk_mem[wr_idx] <= wr_data;
            end else begin
                rk_mem[wr_idx] <= rk_mem[wr_idx];
            end
            if (rk_addr_i <= 4'd10) begin
                rk_data_o <= rk_mem[rk_addr_i];
            end else begin
                rk_data_o <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors plus random keys against a word-level
// key-schedule model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         decrypt_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         busy_o;
    logic         rk_valid_o;
    logic [127:0] round_key_o;
    logic [3:0]   round_idx_o;
    logic [127:0] keylast_o;
    logic         done_o;
`ifdef KEY_STORE_EN
    logic [3:0]   rk_addr_i = 4'd0;
    logic [127:0] rk_data_o;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0]   sb     [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] obs_rk [0:10];
    logic [127:0] saved  [0:10];

    aes_key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .decrypt_i  (decrypt_i),
        .key_i      (key_i),
        .busy_o     (busy_o),
        .rk_valid_o (rk_valid_o),
        .round_key_o(round_key_o),
        .round_idx_o(round_idx_o),
        .keylast_o  (keylast_o),
        .done_o     (done_o)
`ifdef KEY_STORE_EN
        ,
        .rk_addr_i  (rk_addr_i),
        .rk_data_o  (rk_data_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 word-oriented key expansion: w[i] = w[i-4] ^ temp
    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", {127'd0, busy_o}, 128'd0);
    endtask

    // One full expansion, checked cycle by cycle from the cycle after the accepting edge
    task automatic run_exp(input logic [127:0] key, input logic dec);
        logic [127:0] kl_prev;
        int           busy_cnt;
        build_ref(key);
        wait_idle();
        kl_prev   = keylast_o;
        busy_cnt  = 0;
        key_i     = key;
        decrypt_i = dec;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i   = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy_o) busy_cnt++;
            obs_rk[k] = round_key_o;
            chk($sformatf("rk%0d", k), round_key_o, exp_rk[k]);
            chk($sformatf("idx%0d", k), {124'd0, round_idx_o}, 128'(k));
            chk($sformatf("valid%0d", k), {127'd0, rk_valid_o}, 128'd1);
            chk($sformatf("done%0d", k), {127'd0, done_o}, (k == 10) ? 128'd1 : 128'd0);
            if (dec) chk($sformatf("kl_dec%0d", k), keylast_o, key);
            else if (k < 10) chk($sformatf("kl_hold%0d", k), keylast_o, kl_prev);
            else chk("kl_enc", keylast_o, exp_rk[10]);
        end
        @(posedge clk); #1;
        if (busy_o) busy_cnt++;
        chk("busy_cycles", 128'(busy_cnt), 128'd11);
        chk("valid_end", {127'd0, rk_valid_o}, 128'd0);
        chk("done_end", {127'd0, done_o}, 128'd0);
        chk("rk_hold", round_key_o, exp_rk[10]);
    endtask

    initial begin
        int starts;
        int first_c;
        int second_c;
        logic [127:0] rkey;

        build_sbox();

        // Reset state
        #12;
        chk("rst_busy", {127'd0, busy_o}, 128'd0);
        chk("rst_valid", {127'd0, rk_valid_o}, 128'd0);
        chk("rst_key", round_key_o, 128'd0);
        chk("rst_kl", keylast_o, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 Appendix A key, encrypt
        run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        chk("t1_idx1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("t1_idx10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("t1_kl", keylast_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEY_STORE_EN
        rk_addr_i = 4'd10;
        @(posedge clk); #1;
        chk("ks_a10", rk_data_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk_addr_i = 4'd12;
        @(posedge clk); #1;
        chk("ks_a12", rk_data_o, 128'd0);
        rk_addr_i = 4'd1;
        @(posedge clk); #1;
        chk("ks_a1", rk_data_o, 128'ha0fafe1788542cb123a339392a6c7605);
`endif

        // Sequential key, encrypt then decrypt
        run_exp(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        chk("t2_idx10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        for (int r = 0; r <= 10; r++) saved[r] = obs_rk[r];
        run_exp(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        for (int r = 0; r <= 10; r++) chk($sformatf("t3_same%0d", r), obs_rk[r], saved[r]);
        chk("t3_kl", keylast_o, 128'h000102030405060708090a0b0c0d0e0f);

        // start held high: only starts seen in IDLE are taken
        wait_idle();
        starts   = 0;
        first_c  = -1;
        second_c = -1;
        key_i     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        decrypt_i = 1'b0;
        start_i   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rk_valid_o && round_idx_o == 4'd0) begin
                starts++;
                if (first_c < 0) first_c = c;
                else second_c = c;
            end
        end
        start_i = 1'b0;
        wait_idle();
        chk("t4_starts", 128'(starts), 128'd2);
        chk("t4_gap", 128'(second_c - first_c), 128'd12);

        // Asynchronous reset in the middle of a decrypt expansion
        key_i     = 128'h0f0e0d0c0b0a09080706050403020100;
        decrypt_i = 1'b1;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("t5_pre_idx", {124'd0, round_idx_o}, 128'd5);
        rst_n = 1'b0;
        #2;
        chk("t5_busy", {127'd0, busy_o}, 128'd0);
        chk("t5_valid", {127'd0, rk_valid_o}, 128'd0);
        chk("t5_done", {127'd0, done_o}, 128'd0);
        chk("t5_key", round_key_o, 128'd0);
        chk("t5_idx", {124'd0, round_idx_o}, 128'd0);
        chk("t5_kl", keylast_o, 128'd0);
`ifdef KEY_STORE_EN
        chk("t5_rd", rk_data_o, 128'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        chk("t5_after", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Random keys in both directions
        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_exp(rkey, n[0]);
`ifdef KEY_STORE_EN
            for (int a = 0; a <= 10; a++) begin
                rk_addr_i = 4'(a);
                @(posedge clk); #1;
                chk($sformatf("ks_rand%0d", a), rk_data_o, exp_rk[a]);
            end
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
